enemy_y_tracker: RTL and testbench

- Next-generation vertical-position tracker for enemy planes in the m2_control path.
- Holds N_CH independent Y counters, all advanced by a shared rate-selectable move prescaler.
- Each channel runs an explicit IDLE/FLYING lifecycle with a spawn request and a one-cycle edge-escape pulse, so a plane no longer wraps silently.
- Feeds the renderer (y values, active mask) and game logic (escape pulses).

---
 rtl/enemy_pkg.sv | 28 ++
 rtl/enemy_y_channel.sv | 81 ++++++++
 rtl/enemy_y_tracker.sv | 117 +++++++++++
 tb/tb_enemy_y_tracker.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/enemy_pkg.sv
// ---------------------------------------------------------------------------
// enemy_pkg
// Shared definitions for the enemy Y tracker:
//   - ch_state_t      : per-channel lifecycle state (ST_IDLE / ST_FLYING)
//   - DEF_Y_MAX       : default bottom-edge row
//   - DEF_RATE0..3    : default prescaler reload values, slowest to fastest
//   - RATE_SLOWEST..RATE_FASTEST : names for the flying_rate encodings
// ---------------------------------------------------------------------------
package enemy_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_FLYING = 1'b1
    } ch_state_t;

    localparam int DEF_Y_MAX = 120;

    localparam int DEF_RATE0 = 12499999;
    localparam int DEF_RATE1 = 6499999;
    localparam int DEF_RATE2 = 3999999;
    localparam int DEF_RATE3 = 1999999;

    localparam logic [1:0] RATE_SLOWEST = 2'b00;
    localparam logic [1:0] RATE_SLOW    = 2'b01;
    localparam logic [1:0] RATE_FAST    = 2'b10;
    localparam logic [1:0] RATE_FASTEST = 2'b11;

endpackage

// File: rtl/enemy_y_channel.sv
// ---------------------------------------------------------------------------
// enemy_y_channel
// One enemy plane: IDLE/FLYING lifecycle plus its Y register.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   move_tick      : shared one-cycle move strobe from the prescaler
//   spawn          : launch request (accepted only while IDLE)
//   destroyed      : kill request (only meaningful while FLYING)
//   y              : registered Y coordinate, 0..Y_MAX
//   active         : registered, 1 while the channel is FLYING (state view)
//   touch_edge     : registered one-cycle pulse when the plane reaches Y_MAX
// Priority per cycle: destroyed > spawn > move.
// ---------------------------------------------------------------------------
module enemy_y_channel
    import enemy_pkg::*;
#(
    parameter int Y_W   = 8,
    parameter int Y_MAX = DEF_Y_MAX
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           move_tick,
    input  logic           spawn,
    input  logic           destroyed,
    output logic [Y_W-1:0] y,
    output logic           active,
    output logic           touch_edge
);

    localparam logic [Y_W-1:0] Y_TOP  = Y_W'(Y_MAX);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(Y_MAX - 1);

    ch_state_t      state, state_n;
    logic [Y_W-1:0] y_n;
    logic           touch_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            y          <= '0;
            touch_edge <= 1'b0;
        end else begin
            state      <= state_n;
            y          <= y_n;
            touch_edge <= touch_n;
        end
    end

    always_comb begin
        state_n = state;
        y_n     = y;
        touch_n = 1'b0;
        case (state)
            ST_IDLE: begin
                // IDLE y is either 0 or the Y_MAX held for one cycle after
                // an escape; both collapse to 0, whether or not we spawn.
                y_n = '0;
                if (spawn) begin
                    state_n = ST_FLYING;
                end
            end
            ST_FLYING: begin
                if (destroyed) begin
                    state_n = ST_IDLE;
                    y_n     = '0;
                end else if (move_tick) begin
                    if (y == Y_LAST) begin
                        y_n     = Y_TOP;
                        touch_n = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        y_n = y + 1'b1;
                    end
                end
            end
        endcase
    end

    assign active = (state == ST_FLYING);

endmodule

// File: rtl/enemy_y_tracker.sv
// ---------------------------------------------------------------------------
// enemy_y_tracker
// N_CH independent enemy Y trackers advanced by one shared, rate-selectable
// move prescaler.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   move_en        : prescaler enable; low freezes all motion
//   flying_rate    : reload select RATE0 (slowest) .. RATE3 (fastest)
//   spawn          : per-channel launch request, level-sampled
//   destroyed      : per-channel kill request, level-sampled
//   y_flat         : channel i Y at [i*Y_W +: Y_W]
//   active         : per-channel FLYING flag
//   touch_edge     : per-channel one-cycle escape pulse
//   move_tick      : prescaler strobe (m == 0 && move_en)
// Optional (macro ENEMY_Y_ESCAPE_CNT_EN):
//   clr_escape     : synchronous clear of escape_cnt, wins over increments
//   escape_cnt     : saturating (255) count of all escape pulses
// ---------------------------------------------------------------------------
module enemy_y_tracker
    import enemy_pkg::*;
#(
    parameter int N_CH    = 10,
    parameter int Y_W     = 8,
    parameter int Y_MAX   = DEF_Y_MAX,
    parameter int PRESC_W = 24,
    parameter int RATE0   = DEF_RATE0,
    parameter int RATE1   = DEF_RATE1,
    parameter int RATE2   = DEF_RATE2,
    parameter int RATE3   = DEF_RATE3
) (
    input  logic                clk,
    input  logic                reset_n,
`ifdef ENEMY_Y_ESCAPE_CNT_EN
    input  logic                clr_escape,
    output logic [7:0]          escape_cnt,
`endif
    input  logic                move_en,
    input  logic [1:0]          flying_rate,
    input  logic [N_CH-1:0]     spawn,
    input  logic [N_CH-1:0]     destroyed,
    output logic [N_CH*Y_W-1:0] y_flat,
    output logic [N_CH-1:0]     active,
    output logic [N_CH-1:0]     touch_edge,
    output logic                move_tick
);

    logic [PRESC_W-1:0] m;
    logic [PRESC_W-1:0] reload;

    // Reload is looked up only when m wraps, so a rate change never
    // truncates the period already in progress.
    always_comb begin
        reload = PRESC_W'(RATE0);
        case (flying_rate)
            RATE_SLOWEST: reload = PRESC_W'(RATE0);
            RATE_SLOW:    reload = PRESC_W'(RATE1);
            RATE_FAST:    reload = PRESC_W'(RATE2);
            RATE_FASTEST: reload = PRESC_W'(RATE3);
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m <= reload;
        end else if (move_en) begin
            if (m == '0) begin
                m <= reload;
            end else begin
                m <= m - 1'b1;
            end
        end
    end

    assign move_tick = (m == '0) && move_en;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        enemy_y_channel #(
            .Y_W   (Y_W),
            .Y_MAX (Y_MAX)
        ) u_ch (
            .clk        (clk),
            .reset_n    (reset_n),
            .move_tick  (move_tick),
            .spawn      (spawn[i]),
            .destroyed  (destroyed[i]),
            .y          (y_flat[i*Y_W +: Y_W]),
            .active     (active[i]),
            .touch_edge (touch_edge[i])
        );
    end

`ifdef ENEMY_Y_ESCAPE_CNT_EN
    logic [15:0] pulse_sum;
    logic [15:0] cnt_total;

    always_comb begin
        pulse_sum = '0;
        for (int i = 0; i < N_CH; i++) begin
            pulse_sum = pulse_sum + 16'(touch_edge[i]);
        end
        cnt_total = 16'(escape_cnt) + pulse_sum;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            escape_cnt <= 8'd0;
        end else if (clr_escape) begin
            escape_cnt <= 8'd0;
        end else if (cnt_total > 16'd255) begin
            escape_cnt <= 8'hFF;
        end else begin
            escape_cnt <= cnt_total[7:0];
        end
    end
`endif

endmodule

// File: tb/tb_enemy_y_tracker.sv
// ---------------------------------------------------------------------------
// tb_enemy_y_tracker
// Directed bench for enemy_y_tracker with a small configuration
// (Y_MAX=5, RATE0..3 = 3,2,1,0). Escape pulses are checked by a monitor
// against an expected-mask queue filled by the stimulus; timing, freeze,
// destroy and reset behaviour are checked with hand-computed values.
// Build with ENEMY_Y_ESCAPE_CNT_EN to also exercise escape_cnt.
// ---------------------------------------------------------------------------
module tb_enemy_y_tracker;

    localparam int N_CH    = 10;
    localparam int Y_W     = 8;
    localparam int Y_MAX   = 5;
    localparam int PRESC_W = 4;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                reset_n;
    logic                move_en;
    logic [1:0]          flying_rate;
    logic [N_CH-1:0]     spawn;
    logic [N_CH-1:0]     destroyed;
    logic [N_CH*Y_W-1:0] y_flat;
    logic [N_CH-1:0]     active;
    logic [N_CH-1:0]     touch_edge;
    logic                move_tick;
`ifdef ENEMY_Y_ESCAPE_CNT_EN
    logic                clr_escape;
    logic [7:0]          escape_cnt;
    int                  exp_cnt;
`endif

    enemy_y_tracker #(
        .N_CH    (N_CH),
        .Y_W     (Y_W),
        .Y_MAX   (Y_MAX),
        .PRESC_W (PRESC_W),
        .RATE0   (3),
        .RATE1   (2),
        .RATE2   (1),
        .RATE3   (0)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
`ifdef ENEMY_Y_ESCAPE_CNT_EN
        .clr_escape  (clr_escape),
        .escape_cnt  (escape_cnt),
`endif
        .move_en     (move_en),
        .flying_rate (flying_rate),
        .spawn       (spawn),
        .destroyed   (destroyed),
        .y_flat      (y_flat),
        .active      (active),
        .touch_edge  (touch_edge),
        .move_tick   (move_tick)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [N_CH-1:0] exp_q[$];

    function automatic logic [Y_W-1:0] get_y(input int i);
        return y_flat[i*Y_W +: Y_W];
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // driver tasks
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!move_tick && n < 64);
        if (!move_tick) check("tick_timeout", 128'(n), 128'(0));
    endtask

    // scoreboard monitor
    logic [N_CH-1:0] mon_exp;
    bit              mon_ok;

    always @(negedge clk) begin
        if (reset_n) begin
            mon_ok = 1'b1;
            for (int i = 0; i < N_CH; i++) begin
                if (get_y(i) > Y_W'(Y_MAX)) mon_ok = 1'b0;
            end
            check("y_bound", 128'(mon_ok), 128'(1));
            if (touch_edge != '0) begin
                if (exp_q.size() == 0) begin
                    check("touch_unexpected", 128'(touch_edge), 128'(0));
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("touch_mask", 128'(touch_edge), 128'(mon_exp));
                    mon_ok = 1'b1;
                    for (int i = 0; i < N_CH; i++) begin
                        if (touch_edge[i] && (get_y(i) != Y_W'(Y_MAX) || active[i])) mon_ok = 1'b0;
                    end
                    check("touch_y_at_edge", 128'(mon_ok), 128'(1));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int g;

    initial begin
        reset_n     = 1'b0;
        move_en     = 1'b0;
        flying_rate = 2'd0;
        spawn       = '0;
        destroyed   = '0;
`ifdef ENEMY_Y_ESCAPE_CNT_EN
        clr_escape  = 1'b0;
        exp_cnt     = 0;
`endif
        step(3);
        check("rst_y",      128'(y_flat),     128'(0));
        check("rst_active", 128'(active),     128'(0));
        check("rst_touch",  128'(touch_edge), 128'(0));
        check("rst_tick",   128'(move_tick),  128'(0));
`ifdef ENEMY_Y_ESCAPE_CNT_EN
        check("rst_cnt",    128'(escape_cnt), 128'(0));
`endif

        // prescaler period with RATE0=3: tick every 4 cycles
        reset_n = 1'b1;
        move_en = 1'b1;
        wait_tick(g);
        check("first_period", 128'(g), 128'(4));
        wait_tick(g);
        check("period_rate0", 128'(g), 128'(4));
        check("idle_y",      128'(y_flat), 128'(0));
        check("idle_active", 128'(active), 128'(0));

        // rate change mid-count: current period keeps 4, then RATE3=0 gives 1
        step(1);
        flying_rate = 2'd3;
        wait_tick(g);
        check("rate_change_cur", 128'(g), 128'(4));
        wait_tick(g);
        check("rate_change_next", 128'(g), 128'(1));

        // ch0 full flight with a tick every cycle
        exp_q.push_back(10'b00_0000_0001);
        step(1);
        spawn = 10'b00_0000_0001;
        step(1);
        spawn = '0;
        for (int k = 0; k < Y_MAX; k++) begin
            @(negedge clk);
            check("ch0_y_step", 128'(get_y(0)), 128'(k));
            check("ch0_active", 128'(active[0]), 128'(1));
        end
        @(negedge clk);
        check("ch0_y_edge",     128'(get_y(0)),      128'(5));
        check("ch0_touch",      128'(touch_edge[0]), 128'(1));
        @(negedge clk);
        check("ch0_y_after",      128'(get_y(0)),      128'(0));
        check("ch0_active_after", 128'(active[0]),     128'(0));
        check("ch0_touch_after",  128'(touch_edge[0]), 128'(0));

        // ch1..3 together; ch3 destroyed on its final tick; ch1 respawns in its pulse cycle
        exp_q.push_back(10'b00_0000_0110);
        step(1);
        spawn = 10'b00_0000_1110;
        step(1);
        spawn = '0;
        step(4);
        spawn     = 10'b00_0000_0010;
        destroyed = 10'b00_0000_1000;
        step(1);
        destroyed = '0;
        check("ch3_y_destroyed",      128'(get_y(3)),      128'(0));
        check("ch3_active_destroyed", 128'(active[3]),     128'(0));
        check("ch3_no_touch",         128'(touch_edge[3]), 128'(0));
        check("ch1_y_edge",           128'(get_y(1)),      128'(5));
        step(1);
        spawn = '0;
        check("ch1_respawn_y",      128'(get_y(1)),  128'(0));
        check("ch1_respawn_active", 128'(active[1]), 128'(1));
        check("ch2_idle_after",     128'(active[2]), 128'(0));
        step(2);
        check("ch1_pre_freeze_y", 128'(get_y(1)), 128'(2));

        // freeze for 10 cycles
        move_en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            check("freeze_tick", 128'(move_tick), 128'(0));
        end
        check("freeze_y", 128'(get_y(1)), 128'(2));
        exp_q.push_back(10'b00_0000_0010);
        move_en = 1'b1;
        @(negedge clk);
        check("resume_tick", 128'(move_tick), 128'(1));
        check("resume_y0",   128'(get_y(1)),  128'(2));
        step(1);
        check("resume_y1", 128'(get_y(1)), 128'(3));
        step(3);
        check("ch1_done_y",      128'(get_y(1)),  128'(0));
        check("ch1_done_active", 128'(active[1]), 128'(0));

`ifdef ENEMY_Y_ESCAPE_CNT_EN
        exp_cnt = 4;
        check("cnt_prior", 128'(escape_cnt), 128'(exp_cnt));
        exp_q.push_back(10'b00_0111_0000);
        spawn = 10'b00_0111_0000;
        step(1);
        spawn = '0;
        step(6);
        exp_cnt = exp_cnt + 3;
        check("cnt_triple", 128'(escape_cnt), 128'(exp_cnt));
        for (int r = 0; r < 25; r++) begin
            exp_q.push_back('1);
            spawn = '1;
            step(1);
            spawn = '0;
            step(6);
            exp_cnt = (exp_cnt + 10 > 255) ? 255 : exp_cnt + 10;
        end
        check("cnt_sat", 128'(escape_cnt), 128'(exp_cnt));
        exp_q.push_back('1);
        spawn = '1;
        step(1);
        spawn = '0;
        step(5);
        clr_escape = 1'b1;
        step(1);
        clr_escape = 1'b0;
        check("cnt_clr_priority", 128'(escape_cnt), 128'(0));
        step(1);
        check("cnt_clr_hold", 128'(escape_cnt), 128'(0));
`endif

        // reset mid-flight
        spawn = 10'b10_0000_0000;
        step(1);
        spawn = '0;
        step(2);
        check("ch9_y_pre_reset", 128'(get_y(9)), 128'(2));
        reset_n = 1'b0;
        #1;
        check("midrst_y",      128'(y_flat),     128'(0));
        check("midrst_active", 128'(active),     128'(0));
        check("midrst_touch",  128'(touch_edge), 128'(0));
        step(2);
        reset_n = 1'b1;
        step(8);
        check("post_rst_active", 128'(active), 128'(0));
        check("scoreboard_drained", 128'(exp_q.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
